// File: rtl/sdram_rank_router_if.sv
// Controller-side and chip-side bus bundle for the SDRAM rank router.
// The router takes the slave modport. The controller/chip side, or a bench, takes master.
interface sdram_rank_router_if #(
  parameter int SEL_W = 1,
  parameter int ROW_W = 13,
  parameter int BA_W  = 2,
  parameter int DQ_W  = 32
);
  localparam int CHIPS = 2**SEL_W;

  // Controller side
  logic                    cs;
  logic                    ras;
  logic                    cas;
  logic                    we;
  logic [ROW_W+SEL_W-1:0]  a;
  logic [BA_W-1:0]         ba;
  logic [DQ_W/8-1:0]       dqm;
  logic [DQ_W-1:0]         wdata;
  logic [DQ_W-1:0]         rdata;
  logic                    rvalid;
  logic                    err;

  // Chip side
  logic [CHIPS-1:0]        chip_cs;
  logic [ROW_W-1:0]        chip_a;
  logic [BA_W-1:0]         chip_ba;
  logic                    chip_ras;
  logic                    chip_cas;
  logic                    chip_we;
  logic [DQ_W/8-1:0]       chip_dqm;
  logic [DQ_W-1:0]         chip_wdata;
  logic [CHIPS*DQ_W-1:0]   chip_rdata;

  modport master (
    output cs, ras, cas, we, a, ba, dqm, wdata, chip_rdata,
    input  rdata, rvalid, err, chip_cs, chip_a, chip_ba, chip_ras, chip_cas,
           chip_we, chip_dqm, chip_wdata
  );

  modport slave (
    input  cs, ras, cas, we, a, ba, dqm, wdata, chip_rdata,
    output rdata, rvalid, err, chip_cs, chip_a, chip_ba, chip_ras, chip_cas,
           chip_we, chip_dqm, chip_wdata
  );
endinterface

// File: rtl/sdram_rank_router.sv
// Routes one SDRAM command bus to 2**SEL_W chips.
// The chip is picked at ACTIVE from the upper address bits and remembered per bank.
// Read data is steered back through a CAS-latency pipeline and a burst counter.
module sdram_rank_router #(
  parameter int SEL_W = 1,
  parameter int ROW_W = 13,
  parameter int BA_W  = 2,
  parameter int DQ_W  = 32
) (
  input logic                clk,
  input logic                reset,
  sdram_rank_router_if.slave bus
);
  localparam int CHIPS = 2**SEL_W;
  localparam int NBANK = 2**BA_W;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  // One read tag in flight; cl3 records the CAS latency in force when the RD issued.
  typedef struct packed {
    logic             v;
    logic             cl3;
    logic [SEL_W-1:0] chip;
  } tag_t;

  logic [NBANK-1:0] r_open;
  logic [SEL_W-1:0] r_owner [NBANK];
  logic [2:0]       r_cl;
  logic [3:0]       r_bl;
  logic             r_err;
  tag_t             r_pipe [3];
  logic [3:0]       r_cnt;
  logic [SEL_W-1:0] r_chip;
  logic             r_rvalid;
  logic [DQ_W-1:0]  r_rdata;

  cmd_e             w_cmd;
  logic [SEL_W-1:0] w_sel;
  logic             w_bank_open;
  logic [SEL_W-1:0] w_bank_owner;
  logic             w_pre_all;
  logic [2:0]       w_lmr_cl;
  logic [2:0]       w_lmr_bl;
  logic             w_emerge;
  logic [SEL_W-1:0] w_emerge_chip;
  logic [CHIPS-1:0] w_chip_cs;

  assign w_cmd        = bus.cs ? CMD_NOP : cmd_e'({bus.ras, bus.cas, bus.we});
  assign w_sel        = bus.a[ROW_W+SEL_W-1:ROW_W];
  assign w_bank_open  = r_open[bus.ba];
  assign w_bank_owner = r_owner[bus.ba];
  assign w_pre_all    = bus.a[10];
  assign w_lmr_cl     = bus.a[6:4];
  assign w_lmr_bl     = bus.a[2:0];

  // Per-chip select for the command on the bus right now.
  always_comb begin
    // NOTE: default every output first so no path through the case leaves a latch.
    w_chip_cs = '1;
    if (!reset) begin
      case (w_cmd)
        CMD_ACT:                 w_chip_cs[w_sel] = 1'b0;
        CMD_RD, CMD_WR, CMD_BST: if (w_bank_open) w_chip_cs[w_bank_owner] = 1'b0;
        CMD_PRE: begin
          if (w_pre_all)        w_chip_cs = '0;
          else if (w_bank_open) w_chip_cs[w_bank_owner] = 1'b0;
        end
        CMD_REF, CMD_LMR:        w_chip_cs = '0;
        default: ;
      endcase
    end
  end

  // Tag leaving the latency pipeline this cycle; the younger tag wins a collision.
  always_comb begin
    w_emerge      = 1'b0;
    w_emerge_chip = '0;
    if (r_pipe[2].v && r_pipe[2].cl3) begin
      w_emerge      = 1'b1;
      w_emerge_chip = r_pipe[2].chip;
    end
    if (r_pipe[1].v && !r_pipe[1].cl3) begin
      w_emerge      = 1'b1;
      w_emerge_chip = r_pipe[1].chip;
    end
  end

  // Bank-open table, mode register and sticky protocol error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_open <= '0;
      r_cl   <= 3'd3;
      r_bl   <= 4'd1;
      r_err  <= 1'b0;
    end else begin
      case (w_cmd)
        CMD_ACT: begin
          if (w_bank_open) r_err <= 1'b1;
          r_open[bus.ba] <= 1'b1;
        end
        CMD_RD, CMD_WR, CMD_BST: if (!w_bank_open) r_err <= 1'b1;
        CMD_PRE: begin
          if (w_pre_all) r_open <= '0;
          else           r_open[bus.ba] <= 1'b0;
        end
        CMD_LMR: begin
          if (w_lmr_cl == 3'd2 || w_lmr_cl == 3'd3) r_cl <= w_lmr_cl;
          else                                     r_err <= 1'b1;
          if (w_lmr_bl <= 3'd3) r_bl <= 4'd1 << w_lmr_bl;
          else begin
            r_bl  <= 4'd1;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Owning chip of each bank, written at ACTIVE.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; an owner entry is only read while its open flag is set, and the flags are reset.
    if (!reset && w_cmd == CMD_ACT) r_owner[bus.ba] <= w_sel;
  end

  // Latency pipeline, burst counter and registered read-data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
      r_cnt    <= '0;
      r_chip   <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_pipe[0] <= '{v: (w_cmd == CMD_RD) && w_bank_open, cl3: (r_cl == 3'd3), chip: w_bank_owner};
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];

      r_rvalid <= (r_cnt != '0);
      if (r_cnt != '0) r_rdata <= bus.chip_rdata[int'(r_chip)*DQ_W +: DQ_W];

      if (w_emerge) begin
        r_cnt  <= r_bl;
        r_chip <= w_emerge_chip;
      end else if (w_cmd == CMD_BST || w_cmd == CMD_WR) begin
        r_cnt <= '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.chip_cs    = w_chip_cs;
  assign bus.chip_a     = bus.a[ROW_W-1:0];
  assign bus.chip_ba    = bus.ba;
  assign bus.chip_ras   = bus.ras;
  assign bus.chip_cas   = bus.cas;
  assign bus.chip_we    = bus.we;
  assign bus.chip_dqm   = bus.dqm;
  assign bus.chip_wdata = bus.wdata;
  assign bus.rdata      = r_rdata;
  assign bus.rvalid     = r_rvalid;
  assign bus.err        = r_err;
endmodule
